alu_ctrl_stage: RTL and testbench
=================================

# alu_ctrl_stage

Registered ID/EX-side producer for the ALU control interface: decodes ALUOp/funct7/funct3 into the 4-bit ALU control code and selects the second operand. It then holds the code, both operands and the destination register in a one-entry pipeline register with a valid/ready handshake. It sits between the decode stage and the combinational ALU. Every emitted code is one the ALU implements, so the ALU never sees an unsupported code.

## Interface
Parameters:
- DATA_W, 32, operand width
- CNT_W, 16, width of issued-operation counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  decode stage presents an operation
- ready_o  out  1  stage can accept this cycle
- ALUOp_i  in  2  coarse op class from main control
- funct7_i  in  7  instruction funct7
- funct3_i  in  3  instruction funct3
- ALUSrc_i  in  1  1: operand 2 = imm_i; 0: rs2_data_i
- rs1_data_i, rs2_data_i, imm_i  in  DATA_W  operand sources
- rd_i  in  5  destination register
- flush_i  in  1  squash held and incoming operation
- valid_o  out  1  registered operation valid
- ready_i  in  1  execute stage consumes this cycle
- ALUCtrl_o  out  4  ALU control code
- data1_o, data2_o  out  DATA_W  ALU operands
- rd_o  out  5  destination register
- illegal_o  out  1  decode fell through to default
- issue_cnt_o  out  CNT_W  count of operations delivered

## Operation
- ALU codes: add 4'b0010, sub 4'b0110, and 4'b0000, or 4'b0001.
- Decode:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10 (R-type):
    - funct7 0000000/funct3 000 → add
    - funct7 0100000/funct3 000 → sub
    - funct7 0000000/funct3 111 → and
    - funct7 0000000/funct3 110 → or
  - ALUOp 11 (I-type, funct7 ignored): funct3 000 → add; 111 → and; 110 → or.
  - Anything else → code add, illegal_o=1.
- data2 = ALUSrc_i ? imm_i : rs2_data_i; data1 = rs1_data_i.
- ready_o = !valid_o || ready_i (combinational; single entry, no skid).
- Load: valid_i && ready_o && !flush_i → register code, operands, rd, illegal; valid_o←1.
- Drain: valid_o && ready_i with no load → valid_o←0; data fields keep old values.
- issue_cnt_o increments on valid_o && ready_i && !flush_i. Wraps modulo 2^CNT_W.

## Timing
- Latency: 1 cycle from accepted input to valid_o.
- Throughput: 1 op/cycle while ready_i=1.
- Stall (valid_o && !ready_i): all outputs held bit-stable; ready_o=0.
- Simultaneous drain and load: the new operation replaces the old. valid_o stays 1 and the counter increments once.
- flush_i has priority over load and drain. Next edge: valid_o=0, incoming op dropped, counter not incremented. Data fields are don't-care but are retained.
- Reset (async, any time, including mid-stall) → valid_o=0, ALUCtrl_o=4'b0010, data1_o=data2_o=0, rd_o=0, illegal_o=0, issue_cnt_o=0. ready_o=1 while valid_o=0.
- Deassertion of rst_i is synchronous to clk_i at the integration level; the first load can occur on the first edge after deassertion.

## Configuration
- ALU_CTRL_MUL_EN defined:
  - ALUOp 10 with funct7 0000001/funct3 000 decodes to mul, code 4'b0011, illegal_o=0.
  - The downstream ALU must implement 4'b0011.
- ALU_CTRL_MUL_EN undefined: that encoding is illegal. It emits code add with illegal_o=1, and 4'b0011 never appears on ALUCtrl_o.

## Test plan
- Reset, then R-type add (ALUOp 10, f7 0, f3 000, rs1=5, rs2=7, ready_i=1) → next cycle valid_o=1, ALUCtrl_o=0010, data1_o=5, data2_o=7, illegal_o=0; issue_cnt_o=1 one cycle later.
- I-type ori (ALUOp 11, f3 110, f7=0100000, ALUSrc 1, imm=0xF0) → ALUCtrl_o=0001, data2_o=0xF0, illegal_o=0.
- Hold ready_i=0 for 3 cycles after a sub load → ready_o=0, outputs unchanged, counter unchanged. Raise ready_i together with a new and op → next cycle ALUCtrl_o=0000, counter +1.
- flush_i asserted with valid_i=1 and valid_o=1 → next cycle valid_o=0, counter unchanged.
- ALUOp 10, f7 0000001, f3 000 → with ALU_CTRL_MUL_EN: ALUCtrl_o=0011, illegal_o=0; without: ALUCtrl_o=0010, illegal_o=1.
- Preload counter to 0xFFFF via continuous traffic, deliver one more → issue_cnt_o=0. Assert rst_i mid-stall → all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/alu_ctrl_stage_if.sv
// rtl/alu_ctrl_stage_if.sv - decode-to-ALU control channel: decode-side inputs and registered ALU-side outputs
interface alu_ctrl_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              valid_i;
    logic              ready_o;
    logic [1:0]        ALUOp_i;
    logic [6:0]        funct7_i;
    logic [2:0]        funct3_i;
    logic              ALUSrc_i;
    logic [DATA_W-1:0] rs1_data_i;
    logic [DATA_W-1:0] rs2_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [4:0]        rd_i;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [3:0]        ALUCtrl_o;
    logic [DATA_W-1:0] data1_o;
    logic [DATA_W-1:0] data2_o;
    logic [4:0]        rd_o;
    logic              illegal_o;
    logic [CNT_W-1:0]  issue_cnt_o;

    // master is the surrounding pipeline (decode and execute), slave is the stage
    modport master (
        output valid_i, ALUOp_i, funct7_i, funct3_i, ALUSrc_i,
        output rs1_data_i, rs2_data_i, imm_i, rd_i, flush_i, ready_i,
        input  ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, rd_o, illegal_o, issue_cnt_o
    );

    modport slave (
        input  valid_i, ALUOp_i, funct7_i, funct3_i, ALUSrc_i,
        input  rs1_data_i, rs2_data_i, imm_i, rd_i, flush_i, ready_i,
        output ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, rd_o, illegal_o, issue_cnt_o
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ALU control decode with one-entry valid/ready register; ALU_CTRL_MUL_EN adds R-type mul
// Every code emitted is one the ALU implements; unsupported encodings fall back to add and flag illegal_o.
module alu_ctrl_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_ctrl_stage_if.slave    bus
);
    localparam logic [3:0] CODE_AND = 4'b0000;
    localparam logic [3:0] CODE_OR  = 4'b0001;
    localparam logic [3:0] CODE_ADD = 4'b0010;
    localparam logic [3:0] CODE_SUB = 4'b0110;
`ifdef ALU_CTRL_MUL_EN
    localparam logic [3:0] CODE_MUL = 4'b0011;
`endif

    logic [3:0]        ctrl_d;
    logic              illegal_d;
    logic [DATA_W-1:0] data2_d;

    logic              valid_q;
    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data2_q;
    logic [4:0]        rd_q;
    logic              illegal_q;
    logic [CNT_W-1:0]  cnt_q;

    logic load;
    logic deliver;

    always_comb begin
        ctrl_d    = CODE_ADD;
        illegal_d = 1'b0;
        case (bus.ALUOp_i)
            2'b00: ctrl_d = CODE_ADD;
            2'b01: ctrl_d = CODE_SUB;
            2'b10: begin
                case ({bus.funct7_i, bus.funct3_i})
                    10'b0000000_000: ctrl_d = CODE_ADD;
                    10'b0100000_000: ctrl_d = CODE_SUB;
                    10'b0000000_111: ctrl_d = CODE_AND;
                    10'b0000000_110: ctrl_d = CODE_OR;
`ifdef ALU_CTRL_MUL_EN
                    10'b0000001_000: ctrl_d = CODE_MUL;
`endif
                    default:         illegal_d = 1'b1;
                endcase
            end
            default: begin
                // I-type: funct7 carries immediate bits, so only funct3 selects the op
                case (bus.funct3_i)
                    3'b000:  ctrl_d = CODE_ADD;
                    3'b111:  ctrl_d = CODE_AND;
                    3'b110:  ctrl_d = CODE_OR;
                    default: illegal_d = 1'b1;
                endcase
            end
        endcase
    end

    assign data2_d = bus.ALUSrc_i ? bus.imm_i : bus.rs2_data_i;

    // Single entry without skid buffer: accept only when empty or draining this cycle
    assign bus.ready_o = !valid_q || bus.ready_i;
    assign load        = bus.valid_i && bus.ready_o && !bus.flush_i;
    assign deliver     = valid_q && bus.ready_i && !bus.flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CODE_ADD;
            data1_q   <= '0;
            data2_q   <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (deliver) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (bus.flush_i) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q   <= 1'b1;
                ctrl_q    <= ctrl_d;
                data1_q   <= bus.rs1_data_i;
                data2_q   <= data2_d;
                rd_q      <= bus.rd_i;
                illegal_q <= illegal_d;
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.ALUCtrl_o   = ctrl_q;
    assign bus.data1_o     = data1_q;
    assign bus.data2_o     = data2_q;
    assign bus.rd_o        = rd_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.issue_cnt_o = cnt_q;
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - directed self-checking bench for alu_ctrl_stage
module tb_alu_ctrl_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_cnt;

    alu_ctrl_stage_if #(.DATA_W(32), .CNT_W(16)) bus ();

    alu_ctrl_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd);
        bus.valid_i    = v;
        bus.ALUOp_i    = op;
        bus.funct7_i   = f7;
        bus.funct3_i   = f3;
        bus.ALUSrc_i   = src;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
        bus.imm_i      = imm;
        bus.rd_i       = rd;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_valid"},   32'(bus.valid_o),     32'd0);
        check({pfx, "_ctrl"},    32'(bus.ALUCtrl_o),   32'h2);
        check({pfx, "_data1"},   bus.data1_o,          32'd0);
        check({pfx, "_data2"},   bus.data2_o,          32'd0);
        check({pfx, "_rd"},      32'(bus.rd_o),        32'd0);
        check({pfx, "_illegal"}, 32'(bus.illegal_o),   32'd0);
        check({pfx, "_cnt"},     32'(bus.issue_cnt_o), 32'd0);
        check({pfx, "_ready"},   32'(bus.ready_o),     32'd1);
    endtask

    initial begin
        drive(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        check_reset_state("rst");
        rst = 1'b0;

        // R-type add
        drive(1'b1, 2'b10, 7'h00, 3'b000, 1'b0, 32'd5, 32'd7, 32'h99, 5'd3);
        tick();
        check("radd_valid",   32'(bus.valid_o),     32'd1);
        check("radd_ctrl",    32'(bus.ALUCtrl_o),   32'h2);
        check("radd_data1",   bus.data1_o,          32'd5);
        check("radd_data2",   bus.data2_o,          32'd7);
        check("radd_rd",      32'(bus.rd_o),        32'd3);
        check("radd_illegal", 32'(bus.illegal_o),   32'd0);
        check("radd_cnt",     32'(bus.issue_cnt_o), 32'd0);

        // I-type ori, funct7 bits must be ignored
        drive(1'b1, 2'b11, 7'h20, 3'b110, 1'b1, 32'd11, 32'd22, 32'hF0, 5'd4);
        tick();
        check("ori_cnt",     32'(bus.issue_cnt_o), 32'd1);
        check("ori_ctrl",    32'(bus.ALUCtrl_o),   32'h1);
        check("ori_data1",   bus.data1_o,          32'd11);
        check("ori_data2",   bus.data2_o,          32'hF0);
        check("ori_illegal", 32'(bus.illegal_o),   32'd0);

        // sub, then stall three cycles while a different op is offered
        drive(1'b1, 2'b01, 7'h00, 3'b000, 1'b0, 32'h100, 32'h30, 32'd0, 5'd9);
        tick();
        check("sub_ctrl", 32'(bus.ALUCtrl_o),   32'h6);
        check("sub_cnt",  32'(bus.issue_cnt_o), 32'd2);
        bus.ready_i = 1'b0;
        drive(1'b1, 2'b10, 7'h00, 3'b110, 1'b0, 32'hDEAD, 32'hBEEF, 32'd0, 5'd17);
        #1;
        check("stall_ready", 32'(bus.ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(bus.valid_o),     32'd1);
            check("stall_ctrl",  32'(bus.ALUCtrl_o),   32'h6);
            check("stall_data1", bus.data1_o,          32'h100);
            check("stall_data2", bus.data2_o,          32'h30);
            check("stall_rd",    32'(bus.rd_o),        32'd9);
            check("stall_cnt",   32'(bus.issue_cnt_o), 32'd2);
            check("stall_ready", 32'(bus.ready_o),     32'd0);
        end

        // drain and load the same cycle
        bus.ready_i = 1'b1;
        drive(1'b1, 2'b10, 7'h00, 3'b111, 1'b0, 32'd1, 32'd2, 32'd0, 5'd5);
        tick();
        check("and_valid", 32'(bus.valid_o),     32'd1);
        check("and_ctrl",  32'(bus.ALUCtrl_o),   32'h0);
        check("and_cnt",   32'(bus.issue_cnt_o), 32'd3);

        // flush beats both drain and load
        drive(1'b1, 2'b01, 7'h00, 3'b000, 1'b0, 32'd8, 32'd9, 32'd0, 5'd6);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_valid", 32'(bus.valid_o),     32'd0);
        check("flush_cnt",   32'(bus.issue_cnt_o), 32'd3);
        check("flush_ready", 32'(bus.ready_o),     32'd1);

        // mul encoding
        drive(1'b1, 2'b10, 7'h01, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 5'd7);
        tick();
`ifdef ALU_CTRL_MUL_EN
        check("mul_ctrl",    32'(bus.ALUCtrl_o), 32'h3);
        check("mul_illegal", 32'(bus.illegal_o), 32'd0);
`else
        check("mul_ctrl",    32'(bus.ALUCtrl_o), 32'h2);
        check("mul_illegal", 32'(bus.illegal_o), 32'd1);
`endif
        check("mul_cnt", 32'(bus.issue_cnt_o), 32'd3);

        // unsupported R-type: sub funct7 with and funct3
        drive(1'b1, 2'b10, 7'h20, 3'b111, 1'b0, 32'd3, 32'd4, 32'd0, 5'd7);
        tick();
        check("ill_ctrl",    32'(bus.ALUCtrl_o),   32'h2);
        check("ill_illegal", 32'(bus.illegal_o),   32'd1);
        check("ill_cnt",     32'(bus.issue_cnt_o), 32'd4);

        // ALUOp 00 add with immediate operand
        drive(1'b1, 2'b00, 7'h7F, 3'b101, 1'b1, 32'd40, 32'd50, 32'h1234, 5'd31);
        tick();
        check("ld_ctrl",    32'(bus.ALUCtrl_o),   32'h2);
        check("ld_illegal", 32'(bus.illegal_o),   32'd0);
        check("ld_data2",   bus.data2_o,          32'h1234);
        check("ld_rd",      32'(bus.rd_o),        32'd31);
        check("ld_cnt",     32'(bus.issue_cnt_o), 32'd5);

        // continuous traffic up to the counter wrap
        exp_cnt = 16'd5;
        while (exp_cnt != 16'hFFFF) begin
            drive(1'b1, 2'b01, 7'h00, 3'b000, 1'b0, 32'(exp_cnt), 32'd1, 32'd0, 5'd1);
            tick();
            exp_cnt = exp_cnt + 16'd1;
        end
        check("pre_wrap_cnt", 32'(bus.issue_cnt_o), 32'hFFFF);
        tick();
        check("wrap_cnt",   32'(bus.issue_cnt_o), 32'd0);
        check("wrap_valid", 32'(bus.valid_o),     32'd1);

        // async reset in the middle of a stall
        bus.ready_i = 1'b0;
        tick();
        check("pre_rst_valid", 32'(bus.valid_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
